fwpayload_wb_arbiter: RTL and testbench

// - Shares the single fwpayload Wishbone slave path between NM Wishbone masters
//   (mgmt SoC wbs_* port, LA-driven debug master, optional on-chip DMA).
// - Round-robin arbitration. A grant is held for the whole cyc burst.
// - Sits between the user_project_wrapper Wishbone pins/LA logic and the

---
 rtl/fwpayload_wb_pkg.sv | 17 +
 rtl/fwpayload_rr_pick.sv | 30 +++
 rtl/fwpayload_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_fwpayload_wb_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fwpayload_wb_pkg.sv
// Shared types and constants for the fwpayload Wishbone arbiter.
package fwpayload_wb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_MAX_NM = 8;
    localparam int TO_CNT_W   = 8;

    // Index width for n masters, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fwpayload_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NM.
module fwpayload_rr_pick
    import fwpayload_wb_pkg::*;
#(
    parameter  int NM = 2,
    localparam int IW = idx_width(NM)
) (
    input  logic [NM-1:0] req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] winner_o,
    output logic          valid_o
);

    // Scan offsets 1..NM from the last winner; the first hit wins
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int i = 1; i <= NM; i++) begin
            for (int k = 0; k < NM; k++) begin
                if (!valid_o && req_i[k] && (k == (int'(last_i) + i) % NM)) begin
                    winner_o = IW'(k);
                    valid_o  = 1'b1;
                end else begin
                    valid_o  = valid_o;
                end
            end
        end
    end

endmodule

// File: rtl/fwpayload_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of the fwpayload slave path.
// Optional hung-slave timeout: define FWPAYLOAD_WB_ARB_TIMEOUT_EN.
module fwpayload_wb_arbiter
    import fwpayload_wb_pkg::*;
#(
    parameter  int NM = 2,
    parameter  int AW = 32,
    parameter  int DW = 32,
    parameter  int TO = 255,
    localparam int SW = DW / 8,
    localparam int IW = idx_width(NM)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM*SW-1:0] m_sel_i,
    input  logic [NM*AW-1:0] m_adr_i,
    input  logic [NM*DW-1:0] m_dat_i,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [DW-1:0]    m_dat_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [SW-1:0]    s_sel_o,
    output logic [AW-1:0]    s_adr_o,
    output logic [DW-1:0]    s_dat_o,
    input  logic             s_ack_i,
    input  logic [DW-1:0]    s_dat_i,
    output logic [NM-1:0]    gnt_o
);

    arb_state_e    state_q, state_d;
    logic [NM-1:0] gnt_q, gnt_d;
    logic [IW-1:0] rr_last_q, rr_last_d;
    logic [IW-1:0] win_s;
    logic          win_vld_s;
    logic          g_cyc_s;
    logic          g_stb_s;
    logic          to_hit_s;

    fwpayload_rr_pick #(.NM(NM)) u_pick (
        .req_i    (m_cyc_i),
        .last_i   (rr_last_q),
        .winner_o (win_s),
        .valid_o  (win_vld_s)
    );

    // One-hot AND-OR mux of the granted master; everything is zero while no grant is held
    always_comb begin
        g_cyc_s = 1'b0;
        g_stb_s = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        for (int k = 0; k < NM; k++) begin
            g_cyc_s = g_cyc_s | (gnt_q[k] & m_cyc_i[k]);
            g_stb_s = g_stb_s | (gnt_q[k] & m_cyc_i[k] & m_stb_i[k]);
            s_we_o  = s_we_o  | (gnt_q[k] & m_we_i[k]);
            s_sel_o = s_sel_o | (m_sel_i[k*SW +: SW] & {SW{gnt_q[k]}});
            s_adr_o = s_adr_o | (m_adr_i[k*AW +: AW] & {AW{gnt_q[k]}});
            s_dat_o = s_dat_o | (m_dat_i[k*DW +: DW] & {DW{gnt_q[k]}});
        end
    end

    assign s_cyc_o = g_cyc_s & ~to_hit_s;
    assign s_stb_o = g_stb_s & ~to_hit_s;
    assign m_ack_o = gnt_q & {NM{s_ack_i & s_stb_o}};
    assign m_err_o = gnt_q & {NM{to_hit_s}};
    assign m_dat_o = s_dat_i;
    assign gnt_o   = gnt_q;

`ifdef FWPAYLOAD_WB_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q holds the pending cycles before this one, so the hit lands on the TO-th pending cycle
    always_comb begin
        to_hit_s = g_stb_s && (cnt_q == TO_CNT_W'(TO - 1));
        if (g_stb_s && !s_ack_i && !to_hit_s) begin
            cnt_d = cnt_q + TO_CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Timeout counter register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign to_hit_s = 1'b0;
`endif

    // Next-state: arbitrate from IDLE, release when the owner drops cyc or times out
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld_s) begin
                    state_d   = ST_GRANT;
                    gnt_d     = NM'(1) << win_s;
                    rr_last_d = win_s;
                end else begin
                    gnt_d     = '0;
                end
            end
            ST_GRANT: begin
                if (!g_cyc_s || to_hit_s) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else begin
                    gnt_d   = gnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State, grant and round-robin pointer registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            rr_last_q <= IW'(NM - 1);
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: tb/tb_fwpayload_wb_arbiter.sv
// Directed table-driven bench for fwpayload_wb_arbiter (NM=2), plus hand sequences.
module tb_fwpayload_wb_arbiter;

    localparam int TB_TO = 16;
    localparam logic [31:0] ADR0 = 32'h1000_0008;
    localparam logic [31:0] ADR1 = 32'h3000_0004;
    localparam logic [31:0] DAT0 = 32'h1111_2222;
    localparam logic [31:0] DAT1 = 32'hA5A5_0001;
    localparam logic [31:0] SDAT = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        wb_rst_ni;
    logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
    logic [7:0]  m_sel_i;
    logic [63:0] m_adr_i, m_dat_i;
    logic [1:0]  m_ack_o, m_err_o, gnt_o;
    logic [31:0] m_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
    logic [3:0]  s_sel_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst_n;
        logic [1:0] cyc;
        logic [1:0] stb;
        logic       ack;
        logic [1:0] gnt;
        logic       scyc;
        logic       sstb;
        logic [1:0] mack;
    } vec_t;

    vec_t tbl[8];

    fwpayload_wb_arbiter #(.NM(2), .AW(32), .DW(32), .TO(TB_TO)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (wb_rst_ni),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_sel_i   (m_sel_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_dat_o   (m_dat_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_sel_o   (s_sel_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_ack_i   (s_ack_i),
        .s_dat_i   (s_dat_i),
        .gnt_o     (gnt_o)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h required=%h at %0t", nm, fld, act, exp, $time);
        end
    endtask

    // Advance one clock, then apply new inputs and let combinational outputs settle
    task automatic drive(input logic rst, input logic [1:0] cyc, input logic [1:0] stb, input logic ack);
        @(posedge clk);
        #1;
        wb_rst_ni = rst;
        m_cyc_i   = cyc;
        m_stb_i   = stb;
        s_ack_i   = ack;
        #2;
    endtask

    task automatic check(input string nm, input logic [1:0] egnt, input logic ecyc, input logic estb,
                         input logic [1:0] eack, input logic [1:0] eerr);
        logic [31:0] eadr, edat;
        logic [3:0]  esel;
        eadr = (egnt == 2'b01) ? ADR0 : (egnt == 2'b10) ? ADR1 : 32'h0;
        edat = (egnt == 2'b01) ? DAT0 : (egnt == 2'b10) ? DAT1 : 32'h0;
        esel = (egnt == 2'b01) ? 4'h3 : (egnt == 2'b10) ? 4'hC : 4'h0;
        cmp(nm, "gnt",   {30'd0, gnt_o},   {30'd0, egnt});
        cmp(nm, "s_cyc", {31'd0, s_cyc_o}, {31'd0, ecyc});
        cmp(nm, "s_stb", {31'd0, s_stb_o}, {31'd0, estb});
        cmp(nm, "m_ack", {30'd0, m_ack_o}, {30'd0, eack});
        cmp(nm, "m_err", {30'd0, m_err_o}, {30'd0, eerr});
        cmp(nm, "s_adr", s_adr_o, eadr);
        cmp(nm, "s_dat", s_dat_o, edat);
        cmp(nm, "s_sel", {28'd0, s_sel_o}, {28'd0, esel});
        cmp(nm, "s_we",  {31'd0, s_we_o},  {31'd0, egnt[1]});
        cmp(nm, "m_dat", m_dat_o, SDAT);
    endtask

    initial begin
        wb_rst_ni = 1'b0;
        m_cyc_i   = 2'b11;
        m_stb_i   = 2'b11;
        m_we_i    = 2'b10;
        m_sel_i   = {4'hC, 4'h3};
        m_adr_i   = {ADR1, ADR0};
        m_dat_i   = {DAT1, DAT0};
        s_ack_i   = 1'b0;
        s_dat_i   = SDAT;

        // reset with all cyc high, release, master 0 first; then single master-1 write
        tbl[0] = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
        tbl[1] = '{1'b1, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
        tbl[2] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00};
        tbl[3] = '{1'b1, 2'b10, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};
        tbl[4] = '{1'b1, 2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00};
        tbl[5] = '{1'b1, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00};
        tbl[6] = '{1'b1, 2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10};
        tbl[7] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00};

        repeat (2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].rst_n, tbl[i].cyc, tbl[i].stb, tbl[i].ack);
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].scyc, tbl[i].sstb, tbl[i].mack, 2'b00);
        end

        // contention: alternate grants with an idle cycle between them
        for (int t = 0; t < 8; t++) begin
            logic [1:0] oh;
            oh = (t % 2 == 0) ? 2'b01 : 2'b10;
            drive(1'b1, 2'b11, 2'b11, 1'b0);
            check($sformatf("cont%0d_idle", t), 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
            drive(1'b1, 2'b11, 2'b11, 1'b1);
            check($sformatf("cont%0d_xfer", t), oh, 1'b1, 1'b1, oh, 2'b00);
            drive(1'b1, ~oh, ~oh, 1'b0);
            check($sformatf("cont%0d_rel", t), oh, 1'b0, 1'b0, 2'b00, 2'b00);
        end

        // burst: master 0 keeps cyc for 4 strobes while master 1 waits
        drive(1'b1, 2'b11, 2'b11, 1'b0);
        check("burst_idle", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, 2'b11, 2'b11, 1'b1);
            check($sformatf("burst%0d", b), 2'b01, 1'b1, 1'b1, 2'b01, 2'b00);
        end
        drive(1'b1, 2'b10, 2'b10, 1'b0);
        check("burst_rel", 2'b01, 1'b0, 1'b0, 2'b00, 2'b00);
        drive(1'b1, 2'b10, 2'b10, 1'b0);
        check("burst_gap", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        drive(1'b1, 2'b10, 2'b10, 1'b1);
        check("burst_m1", 2'b10, 1'b1, 1'b1, 2'b10, 2'b00);
        drive(1'b1, 2'b00, 2'b00, 1'b0);
        check("burst_m1_rel", 2'b10, 1'b0, 1'b0, 2'b00, 2'b00);

        // mid-transfer reset, then master 0 wins again after release
        drive(1'b1, 2'b01, 2'b01, 1'b0);
        check("mrst_idle", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        drive(1'b1, 2'b01, 2'b01, 1'b0);
        check("mrst_pend", 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
        drive(1'b0, 2'b01, 2'b01, 1'b0);
        check("mrst_assert", 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
        drive(1'b0, 2'b01, 2'b01, 1'b1);
        check("mrst_after", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        drive(1'b1, 2'b11, 2'b11, 1'b0);
        check("mrst_rel", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);

        // slave never acks: timeout releases the grant, or grant is held without the feature
`ifdef FWPAYLOAD_WB_ARB_TIMEOUT_EN
        for (int p = 1; p <= TB_TO; p++) begin
            drive(1'b1, 2'b11, 2'b11, 1'b0);
            if (p < TB_TO) check($sformatf("to_pend%0d", p), 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
            else           check("to_hit", 2'b01, 1'b0, 1'b0, 2'b00, 2'b01);
        end
        drive(1'b1, 2'b11, 2'b11, 1'b0);
        check("to_idle", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        drive(1'b1, 2'b11, 2'b11, 1'b1);
        check("to_other", 2'b10, 1'b1, 1'b1, 2'b10, 2'b00);
        drive(1'b1, 2'b00, 2'b00, 1'b0);
        check("to_rel", 2'b10, 1'b0, 1'b0, 2'b00, 2'b00);
`else
        for (int p = 1; p <= 20; p++) begin
            drive(1'b1, 2'b11, 2'b11, 1'b0);
            check($sformatf("hold%0d", p), 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
        end
        drive(1'b1, 2'b10, 2'b10, 1'b0);
        check("hold_rel", 2'b01, 1'b0, 1'b0, 2'b00, 2'b00);
        drive(1'b1, 2'b10, 2'b10, 1'b0);
        check("hold_idle", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        drive(1'b1, 2'b10, 2'b10, 1'b0);
        check("hold_other", 2'b10, 1'b1, 1'b1, 2'b00, 2'b00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
